uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//   Parametrised oversampling UART receiver; successor to the fixed 8N1 receiver in the UART path.
//   Adds:
//     - configurable data width, oversample ratio and stop-bit count
//     - runtime parity, false-start rejection, framing/parity error flags
//     - single-cycle done strobe
//   Sits between the shared baud tick generator and the command decoder / FIFO.
// PARAMETERS
//   DATA_BITS   8   data bits per frame, 5..9, LSB first
//   OVERSAMPLE 16   baud_rate_tick pulses per bit, even, >=4 (>=8 when UART_RX_MAJORITY_VOTE_EN)
//   STOP_BITS   1   stop bits checked, 1 or 2
// PORTS
//   clk             in   1          system clock
//   reset           in   1          synchronous, active-high reset
//   baud_rate_tick  in   1          1-clk pulse, OVERSAMPLE x baud
//   rx              in   1          async serial line, idle high
//   parity_en       in   1          1 = frame carries a parity bit
//   parity_odd      in   1          1 = odd parity, 0 = even
//   o_rx_data       out  DATA_BITS  last received word, held until next done
//   o_rx_done       out  1          1-clk strobe, frame complete
//   o_rx_busy       out  1          frame in progress
//   o_frame_err     out  1          any stop sample was 0; valid with done, held until next done
//   o_parity_err    out  1          parity mismatch; valid with done, held; 0 when parity_en=0
// BEHAVIOUR
// - Reset and synchroniser
//   - One clock, clk; reset is synchronous and active-high.
//   - On reset: state=IDLE, counters=0, shift reg=0; all outputs 0.
//   - rx passes a 2-flop synchroniser (reset value 1) before all logic; adds 2 clk latency.
//   - Reset mid-frame aborts the frame with no done strobe.
// - Timing
//   - All state/counter changes happen only on clk edges where baud_rate_tick=1.
//   - Exception: o_rx_done clears on the next clk edge regardless of tick.
//   - tick counter width: $clog2(OVERSAMPLE); wraps to 0 after OVERSAMPLE-1.
// - States
//   - IDLE: busy=0. Tick with rx_s=0 -> START, cnt=0.
//     - Latch parity_en/parity_odd here; they are ignored for the rest of the frame.
//   - START: busy=1. At cnt==OVERSAMPLE/2-1, sample rx_s:
//     - 1 -> false start, back to IDLE; no done, no flags change.
//     - 0 -> DATA, cnt=0, bit=0.
//   - DATA: at cnt==OVERSAMPLE-1, shift sample in LSB first, cnt=0.
//     - After DATA_BITS samples -> PARITY if latched parity_en, else STOP.
//   - PARITY: one sample at cnt==OVERSAMPLE-1.
//     - perr = ^data ^ sample ^ parity_odd; then -> STOP.
//   - STOP: STOP_BITS samples at cnt==OVERSAMPLE-1; ferr |= ~sample.
//     - Last stop sample, same edge:
//       - o_rx_data <= shift reg; o_frame_err <= ferr; o_parity_err <= perr.
//       - o_rx_done <= 1; busy <= 0; -> IDLE.
//     - Data is updated even when errors are flagged.
//     - Returning at mid-stop allows back-to-back frames; a new start edge is detected on the next tick.
//   - Illegal state -> IDLE.
// - Bit alignment
//   - Sample points are mid-bit: half-bit start verify, then every OVERSAMPLE ticks.
// - Break condition (rx held 0)
//   - Completes a frame with data=0 and ferr=1.
//   - Receiver re-enters START immediately, then repeats.
// CONFIGURATION
//   UART_RX_MAJORITY_VOTE_EN
//     defined:
//       - DATA/PARITY/STOP bits use 2-of-3 majority of rx_s at cnt OVERSAMPLE-3, -2, -1.
//       - Decision is made at OVERSAMPLE-1.
//       - Start verify stays single-sample.
//     undefined:
//       - Single sample at cnt OVERSAMPLE-1.
//       - No vote registers synthesised.
// TESTING
//   Defaults; 1 tick every 4 clk; parity_en=0 for tests 1-4.
//   1. Frame 0x55, 8N1
//      -> one done pulse (exactly 1 clk wide), data=0x55, ferr=0, perr=0.
//      -> busy=1 from START to last stop sample.
//   2. rx low for 5 ticks, then high
//      -> returns to IDLE; no done; busy pulses then 0; prior data/flags unchanged.
//   3. Frame 0xA3 with stop bit driven 0
//      -> done, data=0xA3, ferr=1; next good frame 0x0F -> ferr=0.
//   4. Back-to-back 0x01, 0xFF, 0x80, zero idle gap
//      -> three dones, data in order.
//   5. parity_en=1, parity_odd=0
//      -> frame 0x07 with parity bit 1 gives perr=0.
//      -> same frame with parity bit 0 gives perr=1.
//      -> parity_odd toggled mid-frame has no effect.
//   6. reset asserted during DATA bit 4
//      -> all outputs 0 next clk, no done.
//      -> next 0x3C frame received correctly.
//      -> With macro: 1-tick glitch at a data mid-bit is rejected.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
// Sits between the shared baud tick generator and the command decoder / FIFO.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: data, parity and stop bits are
// decided by a 2-of-3 vote over the last three ticks of each bit period instead
// of a single sample. Start-bit verification is always a single sample.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level on a tick
// START  | verifying the start bit at its mid-point
// DATA   | shifting in DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit (only when parity was enabled at frame start)
// STOP   | sampling STOP_BITS stop bits, publishing the result on the last one
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_rate_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_done,
    output logic                 o_rx_busy,
    output logic                 o_frame_err,
    output logic                 o_parity_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 ferr;
    logic                 perr;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 bit_sample;

    // Two-flop synchroniser; idle-high reset value so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote_a;
    logic vote_b;

    // Capture the two samples preceding the decision tick of each data/parity/stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (baud_rate_tick &&
                     (state == S_DATA || state == S_PARITY || state == S_STOP)) begin
            if (cnt == CNT_W'(OVERSAMPLE - 3)) vote_a <= rx_s;
            if (cnt == CNT_W'(OVERSAMPLE - 2)) vote_b <= rx_s;
        end
    end

    assign bit_sample = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
    assign bit_sample = rx_s;
`endif

    // Receive FSM with registered outputs; everything but the done strobe moves only on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            ferr         <= 1'b0;
            perr         <= 1'b0;
            o_rx_data    <= '0;
            o_rx_done    <= 1'b0;
            o_rx_busy    <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            if (baud_rate_tick) begin
                case (state)
                    S_IDLE: begin
                        o_rx_busy <= 1'b0;
                        if (!rx_s) begin
                            state     <= S_START;
                            cnt       <= '0;
                            o_rx_busy <= 1'b1;
                            par_en_q  <= parity_en;
                            par_odd_q <= parity_odd;
                        end
                    end
                    S_START: begin
                        if (cnt == CNT_HALF) begin
                            if (rx_s) begin
                                state     <= S_IDLE;
                                cnt       <= '0;
                                o_rx_busy <= 1'b0;
                            end else begin
                                state   <= S_DATA;
                                cnt     <= '0;
                                bit_idx <= '0;
                                ferr    <= 1'b0;
                                perr    <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            shreg <= {bit_sample, shreg[DATA_BITS-1:1]};
                            if (bit_idx == BIT_DATA_LAST) begin
                                bit_idx <= '0;
                                state   <= par_en_q ? S_PARITY : S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            perr  <= (^shreg) ^ bit_sample ^ par_odd_q;
                            state <= S_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt  <= '0;
                            ferr <= ferr | ~bit_sample;
                            if (bit_idx == BIT_STOP_LAST) begin
                                bit_idx      <= '0;
                                o_rx_data    <= shreg;
                                o_frame_err  <= ferr | ~bit_sample;
                                o_parity_err <= perr;
                                o_rx_done    <= 1'b1;
                                o_rx_busy    <= 1'b0;
                                state        <= S_IDLE;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        bit_idx   <= '0;
                        o_rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
